// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART types and constants
package uart_pkg;

    localparam int DATA_BITS        = 8;
    localparam int DEF_CLKS_PER_BIT = 434;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } rx_state_t;

endpackage

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - small byte FIFO between the RX deserialiser and its consumer
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                 clock,
    input  logic                 nRst,
    input  logic                 push,
    input  logic [DATA_BITS-1:0] wdata,
    input  logic                 pop,
    output logic [DATA_BITS-1:0] rdata,
    output logic                 empty,
    output logic                 full
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]          wr_q;
    logic [AW:0]          rd_q;
    logic [DATA_BITS-1:0] mem_q [DEPTH];
    logic                 do_push;
    logic                 do_pop;

    // The extra pointer MSB tells full from empty when the index bits match.
    assign empty   = (wr_q == rd_q);
    assign full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem_q[rd_q[AW-1:0]];

    always_ff @(posedge clock or negedge nRst) begin
        if (!nRst) begin
            wr_q <= '0;
            rd_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem_q[wr_q[AW-1:0]] <= wdata;
                wr_q                <= wr_q + 1'b1;
            end
            if (do_pop) begin
                rd_q <= rd_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 UART receiver with byte FIFO and sticky error flags
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
    parameter int DEPTH        = 4
) (
    input  logic                 clock,
    input  logic                 nRst,
    input  logic                 RX,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 frame_err,
    output logic                 overrun,
    input  logic                 err_clr,
    output logic                 busy
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF_CNT = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(CLKS_PER_BIT - 1);
    localparam logic [2:0]    LAST_IDX = 3'(DATA_BITS - 1);

    rx_state_t            state_q;
    logic [CW-1:0]        cnt_q;
    logic [2:0]           idx_q;
    logic [DATA_BITS-1:0] shift_q;
    logic                 rx_meta_q;
    logic                 rx_s_q;
    logic                 frame_err_q, frame_err_d;
    logic                 overrun_q, overrun_d;
    logic                 stop_sample;
    logic                 push;
    logic                 fifo_empty;
    logic                 fifo_full;

    always_ff @(posedge clock or negedge nRst) begin
        if (!nRst) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            rx_meta_q <= RX;
            rx_s_q    <= rx_meta_q;
        end
    end

    always_ff @(posedge clock or negedge nRst) begin
        if (!nRst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (!rx_s_q) begin
                        state_q <= START;
                        cnt_q   <= '0;
                    end
                end
                START: begin
                    // A start bit that is no longer low at mid-bit was a glitch.
                    if (cnt_q == HALF_CNT) begin
                        cnt_q <= '0;
                        if (!rx_s_q) begin
                            state_q <= DATA;
                            idx_q   <= '0;
                        end else begin
                            state_q <= IDLE;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                DATA: begin
                    if (cnt_q == LAST_CNT) begin
                        shift_q <= {rx_s_q, shift_q[DATA_BITS-1:1]};
                        cnt_q   <= '0;
                        if (idx_q == LAST_IDX) begin
                            state_q <= STOP;
                        end else begin
                            idx_q <= idx_q + 3'd1;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                STOP: begin
                    // Leaving at mid-stop lets the next start edge follow immediately.
                    if (cnt_q == LAST_CNT) begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign stop_sample = (state_q == STOP) && (cnt_q == LAST_CNT);
    assign push        = stop_sample && rx_s_q;

    always_comb begin
        frame_err_d = frame_err_q && !err_clr;
        overrun_d   = overrun_q && !err_clr;
        if (stop_sample && !rx_s_q) begin
            frame_err_d = 1'b1;
        end
        if (push && fifo_full && !rx_ready) begin
            overrun_d = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge nRst) begin
        if (!nRst) begin
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    uart_rx_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock (clock),
        .nRst  (nRst),
        .push  (push),
        .wdata (shift_q),
        .pop   (rx_ready),
        .rdata (rx_data),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

    assign rx_valid  = !fifo_empty;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - directed bench for uart_rx at 16 clocks per bit
module tb_uart_rx;

    localparam int CPB = 16;

    logic       clock;
    logic       nRst;
    logic       RX;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       frame_err;
    logic       overrun;
    logic       err_clr;
    logic       busy;

    int n_chk;
    int n_pass;

    uart_rx #(
        .CLKS_PER_BIT (CPB),
        .DEPTH        (4)
    ) dut (
        .clock     (clock),
        .nRst      (nRst),
        .RX        (RX),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .frame_err (frame_err),
        .overrun   (overrun),
        .err_clr   (err_clr),
        .busy      (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        RX = 1'b0;
        tick(CPB);
        for (int i = 0; i < 8; i++) begin
            RX = b[i];
            tick(CPB);
        end
        RX = stop_bit;
        tick(CPB);
        RX = 1'b1;
    endtask

    task automatic pop_one();
        rx_ready = 1'b1;
        tick(1);
        rx_ready = 1'b0;
    endtask

    initial begin
        n_chk    = 0;
        n_pass   = 0;
        nRst     = 1'b0;
        RX       = 1'b1;
        rx_ready = 1'b0;
        err_clr  = 1'b0;
        tick(3);
        chk("rst_data", rx_data, 8'h00);
        chk("rst_valid", rx_valid, 0);
        chk("rst_ferr", frame_err, 0);
        chk("rst_ovr", overrun, 0);
        chk("rst_busy", busy, 0);
        nRst = 1'b1;
        tick(20);

        // 1: single good frame, then pop
        send_frame(8'hA5, 1'b1);
        chk("t1_valid", rx_valid, 1);
        chk("t1_data", rx_data, 8'hA5);
        chk("t1_ferr", frame_err, 0);
        chk("t1_ovr", overrun, 0);
        chk("t1_busy", busy, 0);
        pop_one();
        chk("t1_pop_valid", rx_valid, 0);
        tick(10);

        // 2: short low glitch is rejected in START
        RX = 1'b0;
        tick(4);
        chk("t2_busy_hi", busy, 1);
        RX = 1'b1;
        tick(20);
        chk("t2_busy_lo", busy, 0);
        chk("t2_valid", rx_valid, 0);
        chk("t2_ferr", frame_err, 0);
        chk("t2_ovr", overrun, 0);

        // 3: bad stop bit, clear, then good frame
        send_frame(8'h3C, 1'b0);
        chk("t3_ferr_set", frame_err, 1);
        tick(20);
        chk("t3_no_push", rx_valid, 0);
        chk("t3_busy", busy, 0);
        err_clr = 1'b1;
        tick(1);
        err_clr = 1'b0;
        chk("t3_ferr_clr", frame_err, 0);
        send_frame(8'h5A, 1'b1);
        chk("t3_valid", rx_valid, 1);
        chk("t3_data", rx_data, 8'h5A);
        chk("t3_ferr", frame_err, 0);
        pop_one();
        tick(10);

        // 4: five back-to-back frames into a 4-deep FIFO
        for (int i = 1; i <= 5; i++) begin
            send_frame(8'(i), 1'b1);
            if (i == 4) chk("t4_no_ovr_yet", overrun, 0);
        end
        chk("t4_ovr", overrun, 1);
        chk("t4_ferr", frame_err, 0);
        rx_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            chk("t4_pop_valid", rx_valid, 1);
            chk("t4_pop_data", rx_data, 8'(i));
            tick(1);
        end
        rx_ready = 1'b0;
        chk("t4_empty", rx_valid, 0);
        err_clr = 1'b1;
        tick(1);
        err_clr = 1'b0;
        chk("t4_ovr_clr", overrun, 0);
        tick(10);

        // 5: 0x00 then 0xFF with no idle gap
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        chk("t5_data0", rx_data, 8'h00);
        pop_one();
        chk("t5_valid1", rx_valid, 1);
        chk("t5_data1", rx_data, 8'hFF);
        pop_one();
        chk("t5_empty", rx_valid, 0);
        chk("t5_ferr", frame_err, 0);
        chk("t5_ovr", overrun, 0);
        tick(10);

        // 6: reset in the middle of 0x77, then 0x81
        RX = 1'b0;
        tick(CPB);
        for (int i = 0; i < 3; i++) begin
            RX = (8'h77 >> i) & 1;
            tick(CPB);
        end
        chk("t6_busy_pre", busy, 1);
        nRst = 1'b0;
        #1;
        chk("t6_busy_rst", busy, 0);
        RX = 1'b1;
        tick(3);
        nRst = 1'b1;
        tick(20);
        chk("t6_no_partial", rx_valid, 0);
        send_frame(8'h81, 1'b1);
        chk("t6_valid", rx_valid, 1);
        chk("t6_data", rx_data, 8'h81);
        pop_one();
        chk("t6_empty", rx_valid, 0);
        chk("t6_ferr", frame_err, 0);
        chk("t6_ovr", overrun, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
